// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records retired instructions into a FIFO for readout,
// tracks instruction/cycle/drop counters and a RUN/DRAIN/DONE/TIMEOUT lifecycle.
module commit_trace_buffer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              commit_valid,
  input  logic [ADDR_W-1:0] commit_pc,
  input  logic              commit_regwrite,
  input  logic [3:0]        commit_reg,
  input  logic [DATA_W-1:0] commit_wdata,
  input  logic              commit_memread,
  input  logic              commit_memwrite,
  input  logic [ADDR_W-1:0] commit_maddr,
  input  logic [DATA_W-1:0] commit_mdata,
  input  logic              commit_halt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  rd_inum,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [2:0]        rd_kind,
  output logic [3:0]        rd_reg,
  output logic [DATA_W-1:0] rd_value,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam bit WDOG_EN = (WDOG_LIMIT != 0);
  localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG_LIMIT);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2, S_TIMEOUT = 2'd3} state_e;
  typedef enum logic [2:0] {K_OTHER = 3'd0, K_REG = 3'd1, K_LOAD = 3'd2, K_STORE = 3'd3, K_HALT = 3'd4} kind_e;

  typedef struct packed {
    logic [CNT_W-1:0]  inum;
    logic [ADDR_W-1:0] pc;
    kind_e             kind;
    logic [3:0]        rreg;
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  inst_q, inst_d, cyc_q, cyc_d, drop_q, drop_d;
  logic              ovf_q, ovf_d;
  entry_t            mem_q [DEPTH];
  entry_t            new_entry, head;
  logic              empty, full, empty_d;
  logic              accept_en, cnt_cycle;
  logic              accepting, push, pop, drop, wdog_hit;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign accepting = accept_en && commit_valid && !restart;
  assign pop       = !empty && rd_ready && !restart;
  assign push      = accepting && (!full || pop);
  assign drop      = accepting && full && !pop;

  // Build the entry; fields that do not apply to the kind are forced to zero.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch can be inferred.
    new_entry      = '0;
    new_entry.inum = inst_q;
    new_entry.pc   = commit_pc;
    if (commit_halt) begin
      new_entry.kind = K_HALT;
    end else if (commit_regwrite && commit_memread) begin
      new_entry.kind  = K_LOAD;
      new_entry.rreg  = commit_reg;
      new_entry.value = commit_wdata;
      new_entry.addr  = commit_maddr;
    end else if (commit_regwrite) begin
      new_entry.kind  = K_REG;
      new_entry.rreg  = commit_reg;
      new_entry.value = commit_wdata;
    end else if (commit_memwrite) begin
      new_entry.kind  = K_STORE;
      new_entry.value = commit_mdata;
      new_entry.addr  = commit_maddr;
    end else begin
      new_entry.kind = K_OTHER;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    inst_d   = inst_q;
    cyc_d    = cyc_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (push)      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
    if (accepting) inst_d   = sat_inc(inst_q);
    if (cnt_cycle) cyc_d    = sat_inc(cyc_q);
    if (drop) begin
      drop_d = sat_inc(drop_q);
      ovf_d  = 1'b1;
    end
    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      inst_d   = '0;
      cyc_d    = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end
  end

  assign empty_d  = (rd_ptr_d == wr_ptr_d);
  assign wdog_hit = WDOG_EN && (cyc_d == WDOG_CNT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)          state_q <= S_RUN;
    else if (restart) state_q <= S_RUN;
    else              state_q <= state_d;
  end

  // Next state: a halt commit takes priority over a watchdog expiry on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (accepting && commit_halt) state_d = S_DRAIN;
        else if (wdog_hit)            state_d = S_TIMEOUT;
      end
      S_DRAIN:   if (empty_d) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      S_TIMEOUT: state_d = S_TIMEOUT;
      default:   state_d = S_RUN;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    accept_en = 1'b0;
    cnt_cycle = 1'b0;
    case (state_q)
      S_RUN: begin
        accept_en = 1'b1;
        cnt_cycle = 1'b1;
      end
      S_DRAIN: cnt_cycle = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      inst_q   <= '0;
      cyc_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      inst_q   <= inst_d;
      cyc_q    <= cyc_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale contents are never visible because the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= new_entry;
  end

  assign head     = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign rd_valid = !empty;
  assign rd_inum  = head.inum;
  assign rd_pc    = head.pc;
  assign rd_kind  = head.kind;
  assign rd_reg   = head.rreg;
  assign rd_value = head.value;
  assign rd_addr  = head.addr;

  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;
  assign state       = state_q;

endmodule
